// File: rtl/cbs.sv
// cbs: single-cycle 32-bit load/store core with internal instruction ROM,
// register file and data memory; only clk and rst cross the boundary.
package opcodes_pkg;
    localparam int OPCODES_WIDTH = 4;
    localparam logic [OPCODES_WIDTH-1:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND = 4'd3,
        OR = 4'd4, XOR = 4'd5, SLT = 4'd6, LW = 4'd7, SW = 4'd8, BEQ = 4'd9, BNE = 4'd10;
endpackage

package cmp_pkg;
    function automatic logic taken(input logic beq, input logic bne, input logic equal);
        return (beq && equal) || (bne && !equal);
    endfunction
endpackage

module cbs_mem #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 32,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ADDR-1:0]  waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [ADDR-1:0]  raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] data [DEPTH];
    // addresses beyond the physical depth read as zero and drop writes
    assign rdata = int'(raddr) < DEPTH ? data[raddr] : '0;
    always_ff @(posedge clk)
        if (we && int'(waddr) < DEPTH) data[waddr] <= wdata;
endmodule

module cbs_regs #(
    parameter int NUM   = 5,
    parameter int WIDTH = 32,
    parameter int SEL   = $clog2(NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL-1:0]   waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [SEL-1:0]   raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [SEL-1:0]   raddr_b,
    output logic [WIDTH-1:0] rdata_b
);
    logic [WIDTH-1:0] data [NUM];
    assign rdata_a = int'(raddr_a) < NUM ? data[raddr_a] : '0;
    assign rdata_b = int'(raddr_b) < NUM ? data[raddr_b] : '0;
    always_ff @(posedge clk)
        if (!rst) data <= '{default: '0};
        else if (we && int'(waddr) < NUM) data[waddr] <= wdata;
endmodule

module cbs
    import opcodes_pkg::*;
#(
    parameter int NUM_REG   = 5,
    parameter int REG_WIDTH = 32,
    parameter int NUM_INSTR = 10,
    parameter int NUM_MEM   = 5
) (
    input logic clk,
    input logic rst
);
    localparam int REG_SELECT   = $clog2(NUM_REG);
    localparam int MEM_SELECT   = $clog2(NUM_MEM);
    localparam int PC_WIDTH     = $clog2(NUM_INSTR);
    localparam int OFFSET_WIDTH = REG_WIDTH - OPCODES_WIDTH - 3 * REG_SELECT;

    logic [PC_WIDTH-1:0]      pc, pc_next;
    logic [REG_WIDTH-1:0]     instruction, a, b, alu_data, new_reg, offset, mem_rdata, target;
    logic [OPCODES_WIDTH-1:0] opcode;
    logic [REG_SELECT-1:0]    reg_a, reg_b, reg_c_select;
    logic [MEM_SELECT-1:0]    address;
    logic                     is_write, is_store, taken;

    assign {opcode, reg_a, reg_b, reg_c_select} =
        instruction[REG_WIDTH-1 -: OPCODES_WIDTH + 3 * REG_SELECT];
    assign offset = {{(REG_WIDTH - OFFSET_WIDTH){instruction[OFFSET_WIDTH-1]}},
                     instruction[OFFSET_WIDTH-1:0]};

    assign address  = MEM_SELECT'(a + offset);
    assign is_write = opcode >= ADD && opcode <= LW;
    assign is_store = opcode == SW;
    assign taken    = cmp_pkg::taken(opcode == BEQ, opcode == BNE, a == b);
    assign new_reg  = opcode == LW ? mem_rdata : alu_data;

    always_comb begin
        alu_data = opcode == ADD ? a + b :
                   opcode == SUB ? a - b :
                   opcode == AND ? a & b :
                   opcode == OR  ? a | b :
                   opcode == XOR ? a ^ b :
                   opcode == SLT ? REG_WIDTH'($signed(a) < $signed(b)) : a + offset;
    end

    // out-of-range branch targets (including negative ones, which wrap high) restart at 0
    always_comb begin
        target  = REG_WIDTH'(pc) + REG_WIDTH'(1) + offset;
        pc_next = taken && target < NUM_INSTR ? PC_WIDTH'(target) :
                  taken || pc == PC_WIDTH'(NUM_INSTR - 1) ? '0 : pc + 1'b1;
    end

    always_ff @(posedge clk)
        if (!rst) pc <= '0;
        else pc <= pc_next;

    cbs_mem #(.DEPTH(NUM_INSTR), .WIDTH(REG_WIDTH)) INSTRUCTIONS (
        .clk(clk), .we(1'b0), .waddr(pc), .wdata('0), .raddr(pc), .rdata(instruction)
    );

    cbs_regs #(.NUM(NUM_REG), .WIDTH(REG_WIDTH)) REGISTERS (
        .clk(clk), .rst(rst), .we(is_write), .waddr(reg_c_select), .wdata(new_reg),
        .raddr_a(reg_a), .rdata_a(a), .raddr_b(reg_b), .rdata_b(b)
    );

    cbs_mem #(.DEPTH(NUM_MEM), .WIDTH(REG_WIDTH)) MEM (
        .clk(clk), .we(is_store && rst), .waddr(address), .wdata(b), .raddr(address),
        .rdata(mem_rdata)
    );
endmodule

// File: tb/tb_cbs.sv
// tb_cbs: directed programs plus randomized programs checked against a behavioural ISA model.
module tb_cbs;
    localparam int NOP = 0, ADD = 1, SUB = 2, AND = 3, OR = 4, XOR = 5, SLT = 6,
                   LW = 7, SW = 8, BEQ = 9, BNE = 10;

    logic clk = 0;
    logic rst = 0;
    int checks = 0;
    int errors = 0;
    logic [31:0] rom [10];
    logic [31:0] m_reg [5];
    logic [31:0] m_mem [5];
    int m_pc;

    cbs dut (.clk(clk), .rst(rst));

    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input int op, input int ra, input int rb, input int rc,
                                        input int off);
        return {op[3:0], ra[2:0], rb[2:0], rc[2:0], off[18:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_rom;
        for (int i = 0; i < 10; i++) dut.INSTRUCTIONS.data[i] = rom[i];
    endtask

    task automatic sync_mem;
        for (int i = 0; i < 5; i++) dut.MEM.data[i] = m_mem[i];
    endtask

    task automatic do_reset;
        rst = 0;
        tick();
        rst = 1;
    endtask

    // ISA-level model: one instruction (or a reset) per call
    task automatic model_step;
        logic [31:0] ins, av, bv, v, s;
        int op, ra, rb, rc, off, addr, t, npc;
        if (!rst) begin
            m_pc = 0;
            for (int i = 0; i < 5; i++) m_reg[i] = 0;
            return;
        end
        ins = rom[m_pc];
        op = int'(ins[31:28]);
        ra = int'(ins[27:25]);
        rb = int'(ins[24:22]);
        rc = int'(ins[21:19]);
        off = int'($signed(ins[18:0]));
        av = ra < 5 ? m_reg[ra] : 0;
        bv = rb < 5 ? m_reg[rb] : 0;
        s = av + off;
        addr = int'(s & 32'd7);
        npc = (m_pc + 1) % 10;
        v = 0;
        case (op)
            ADD: v = av + bv;
            SUB: v = av - bv;
            AND: v = av & bv;
            OR:  v = av | bv;
            XOR: v = av ^ bv;
            SLT: v = $signed(av) < $signed(bv) ? 1 : 0;
            LW:  v = addr < 5 ? m_mem[addr] : 0;
            SW:  if (addr < 5) m_mem[addr] = bv;
            default: ;
        endcase
        if (op >= ADD && op <= LW && rc < 5) m_reg[rc] = v;
        if ((op == BEQ && av == bv) || (op == BNE && av != bv)) begin
            t = m_pc + 1 + off;
            npc = (t >= 0 && t < 10) ? t : 0;
        end
        m_pc = npc;
    endtask

    task automatic test_reset;
        m_mem = '{32'd1, 32'd2, 32'd10, 32'd0, 32'd11};
        sync_mem();
        for (int i = 0; i < 10; i++) rom[i] = 0;
        sync_rom();
        rst = 0;
        tick();
        tick();
        checks++;
        if (dut.pc !== 4'd0) begin
            errors++;
            $display("FAIL reset_pc got %0d want 0", dut.pc);
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (dut.REGISTERS.data[r] !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d got %h want 0", r, dut.REGISTERS.data[r]);
            end
        end
        for (int m = 0; m < 5; m++) begin
            checks++;
            if (dut.MEM.data[m] !== m_mem[m]) begin
                errors++;
                $display("FAIL reset_mem%0d got %h want %h", m, dut.MEM.data[m], m_mem[m]);
            end
        end
    endtask

    task automatic test_program;
        int ep [10] = '{1, 2, 3, 4, 5, 7, 8, 9, 0, 1};
        int er [10] = '{4, 0, 1, 2, 2, 2, 4, 2, 0, 4};
        logic [31:0] ev [10] = '{1, 1, 2, 3, 3, 3, 1, 3, 0, 1};
        logic [31:0] fin [5] = '{0, 2, 3, 0, 1};
        logic [31:0] fmem [5] = '{1, 2, 10, 3, 11};
        rom = '{enc(LW, 0, 0, 4, 0), enc(LW, 0, 0, 0, 0), enc(LW, 0, 0, 1, 0),
                enc(ADD, 1, 0, 2, 0), enc(SW, 2, 2, 0, 0), enc(BEQ, 2, 2, 0, 1),
                enc(ADD, 1, 1, 4, 0), 32'd0, enc(ADD, 1, 0, 2, 0), enc(SUB, 0, 0, 0, 0)};
        sync_rom();
        rst = 0;
        tick();
        rst = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (dut.pc !== 4'(ep[k])) begin
                errors++;
                $display("FAIL prog_pc edge%0d got %0d want %0d", k + 1, dut.pc, ep[k]);
            end
            checks++;
            if (dut.REGISTERS.data[er[k]] !== ev[k]) begin
                errors++;
                $display("FAIL prog_r%0d edge%0d got %h want %h", er[k], k + 1,
                         dut.REGISTERS.data[er[k]], ev[k]);
            end
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (dut.REGISTERS.data[r] !== fin[r]) begin
                errors++;
                $display("FAIL prog_final_r%0d got %h want %h", r, dut.REGISTERS.data[r], fin[r]);
            end
        end
        for (int m = 0; m < 5; m++) begin
            checks++;
            if (dut.MEM.data[m] !== fmem[m]) begin
                errors++;
                $display("FAIL prog_mem%0d got %h want %h", m, dut.MEM.data[m], fmem[m]);
            end
        end
    endtask

    task automatic test_branches;
        int ep [7] = '{1, 2, 3, 6, 4, 0, 1};
        rom = '{enc(LW, 0, 0, 1, 1), enc(BNE, 1, 1, 0, 3), enc(BEQ, 1, 0, 0, 3),
                enc(BNE, 1, 0, 0, 2), enc(BEQ, 0, 0, 0, 5), 32'd0, enc(BEQ, 0, 0, 0, -3),
                32'd0, 32'd0, 32'd0};
        sync_rom();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (dut.pc !== 4'(ep[k])) begin
                errors++;
                $display("FAIL branch_pc step%0d got %0d want %0d", k, dut.pc, ep[k]);
            end
        end
        checks++;
        if (dut.REGISTERS.data[0] !== 32'd0 || dut.REGISTERS.data[1] !== 32'd2) begin
            errors++;
            $display("FAIL branch_regs got r0=%h r1=%h want 0 2",
                     dut.REGISTERS.data[0], dut.REGISTERS.data[1]);
        end
    endtask

    task automatic test_corners;
        int er [10] = '{3, 2, 1, 2, 4, 4, 4, 0, 0, 2};
        logic [31:0] ev [10] = '{1, 2, 32'hFFFF_FFFF, 0, 1, 1, 0, 2, 2, 1};
        logic [31:0] fin [5] = '{2, 32'hFFFF_FFFF, 1, 1, 0};
        logic [31:0] fmem [5] = '{1, 2, 10, 3, 11};
        rom = '{enc(LW, 0, 0, 3, 0), enc(LW, 0, 0, 2, 1), enc(SUB, 0, 3, 1, 0),
                enc(ADD, 1, 3, 2, 0), enc(SLT, 1, 3, 4, 0), enc(SW, 0, 3, 0, 6),
                enc(LW, 0, 0, 4, 6), enc(ADD, 3, 3, 0, 0), enc(ADD, 3, 3, 7, 0),
                enc(ADD, 7, 3, 2, 0)};
        sync_rom();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (dut.REGISTERS.data[er[k]] !== ev[k]) begin
                errors++;
                $display("FAIL corner_r%0d edge%0d got %h want %h", er[k], k + 1,
                         dut.REGISTERS.data[er[k]], ev[k]);
            end
        end
        for (int r = 0; r < 5; r++) begin
            checks++;
            if (dut.REGISTERS.data[r] !== fin[r]) begin
                errors++;
                $display("FAIL corner_final_r%0d got %h want %h", r, dut.REGISTERS.data[r], fin[r]);
            end
        end
        for (int m = 0; m < 5; m++) begin
            checks++;
            if (dut.MEM.data[m] !== fmem[m]) begin
                errors++;
                $display("FAIL corner_mem%0d got %h want %h", m, dut.MEM.data[m], fmem[m]);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] fmem [5] = '{1, 2, 10, 3, 11};
        do_reset();
        for (int k = 0; k < 4; k++) tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (dut.pc !== 4'd0) begin
                errors++;
                $display("FAIL midreset_pc got %0d want 0", dut.pc);
            end
            for (int r = 0; r < 5; r++) begin
                checks++;
                if (dut.REGISTERS.data[r] !== 32'd0) begin
                    errors++;
                    $display("FAIL midreset_r%0d got %h want 0", r, dut.REGISTERS.data[r]);
                end
            end
        end
        for (int m = 0; m < 5; m++) begin
            checks++;
            if (dut.MEM.data[m] !== fmem[m]) begin
                errors++;
                $display("FAIL midreset_mem%0d got %h want %h", m, dut.MEM.data[m], fmem[m]);
            end
        end
        rst = 1;
        tick();
        checks++;
        if (dut.pc !== 4'd1 || dut.REGISTERS.data[3] !== 32'd1) begin
            errors++;
            $display("FAIL midreset_restart got pc=%0d r3=%h want pc=1 r3=1",
                     dut.pc, dut.REGISTERS.data[3]);
        end
    endtask

    task automatic test_random;
        logic [31:0] pool [4];
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 10; i++)
                rom[i] = enc($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), int'($urandom_range(0, 24)) - 12);
            pool = '{$urandom(), 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
            for (int m = 0; m < 5; m++) m_mem[m] = pool[$urandom_range(0, 3)];
            sync_rom();
            sync_mem();
            rst = 0;
            model_step();
            tick();
            for (int c = 0; c < 200; c++) begin
                rst = $urandom_range(0, 39) != 0;
                model_step();
                tick();
                checks++;
                if (dut.pc !== 4'(m_pc)) begin
                    errors++;
                    $display("FAIL rand_pc prog%0d cyc%0d got %0d want %0d", p, c, dut.pc, m_pc);
                end
                for (int r = 0; r < 5; r++) begin
                    checks++;
                    if (dut.REGISTERS.data[r] !== m_reg[r]) begin
                        errors++;
                        $display("FAIL rand_r%0d prog%0d cyc%0d got %h want %h", r, p, c,
                                 dut.REGISTERS.data[r], m_reg[r]);
                    end
                end
                for (int m = 0; m < 5; m++) begin
                    checks++;
                    if (dut.MEM.data[m] !== m_mem[m]) begin
                        errors++;
                        $display("FAIL rand_mem%0d prog%0d cyc%0d got %h want %h", m, p, c,
                                 dut.MEM.data[m], m_mem[m]);
                    end
                end
            end
        end
        rst = 1;
    endtask

    initial begin
        test_reset();
        test_program();
        test_branches();
        test_corners();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cbs.md
Name: cbs

Overview:
- Single-cycle, non-pipelined 32-bit load/store processor core; the top of the CBS block.
- Contains its own instruction ROM, register file and data memory. No external bus; only clock and reset cross the boundary.
- Benches load programs and data by hierarchical writes to internal arrays. Those instance and array names are therefore part of the contract.

Parameters:
- NUM_REG, 5, number of general registers; REG_SELECT = $clog2(NUM_REG) (localparam).
- REG_WIDTH, 32, data/instruction word width.
- NUM_INSTR, 10, instruction memory depth; PC width = $clog2(NUM_INSTR).
- NUM_MEM, 5, data memory depth; MEM_SELECT = $clog2(NUM_MEM) (localparam).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.

Behaviour:
Required internal instances and arrays (hierarchically accessible):
- INSTRUCTIONS.data[NUM_INSTR], REGISTERS.data[NUM_REG], MEM.data[NUM_MEM], all REG_WIDTH wide.
- Required internal signals: pc, instruction, reg_a, a, reg_b, b, reg_c_select, is_write, alu_data, new_reg, offset.

Instruction format (MSB to LSB):
- opcode: OPCODES_WIDTH = 4 bits, from opcodes_pkg.
- reg_a: REG_SELECT bits.
- reg_b: REG_SELECT bits.
- reg_c_select: REG_SELECT bits.
- offset: remaining bits (19 at defaults), sign-extended to REG_WIDTH.

Opcodes (opcodes_pkg):
- NOP=0 (an all-zero word is a NOP), ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLT=6 (signed), LW=7, SW=8, BEQ=9, BNE=10. Codes 11-15 behave as NOP.

Datapath:
- Combinational: instruction = INSTRUCTIONS.data[pc]; a = REGISTERS.data[reg_a]; b = REGISTERS.data[reg_b].
- Register read of an index >= NUM_REG returns 0.

Per-opcode behaviour:
- ALU ops: alu_data = a op b, wrapping 32-bit arithmetic; REGISTERS[reg_c_select] <= alu_data.
- LW: address = a + offset; REGISTERS[reg_c_select] <= MEM.data[address].
- SW: address = a + offset; MEM.data[address] <= b; no register write.
- BEQ/BNE: compare a and b (cmp_pkg); no register or memory write.
- NOP: no state change except PC.
- new_reg = the value being written to the register file; is_write = 1 on register-writing opcodes.
- Memory address is the low MEM_SELECT bits. Address >= NUM_MEM: reads return 0, writes are dropped.
- Register write to an index >= NUM_REG is dropped. Register 0 is an ordinary writable register.

PC:
- Next PC = pc+1; wraps to 0 after NUM_INSTR-1.
- Taken branch: pc+1+offset. A target outside 0..NUM_INSTR-1 gives pc = 0.

Timing and reset:
- Latency: exactly one instruction per cycle. The register, memory and PC updates of an instruction all commit at the same rising edge.
- Reset (rst==0 at a rising edge): pc <= 0; all REGISTERS cleared to 0; no memory or register write from the current instruction.
- MEM and INSTRUCTIONS are not cleared by reset and keep preloaded contents.
- Reset mid-program: program restarts at pc 0 on the first edge with rst==1.
- Read-after-write: the reading instruction sees the value committed at the previous edge; there are no intra-cycle hazards.

Test Plan:
- Preload MEM[0]=1, MEM[1]=2; program LW r4,(r0+0); LW r0,(r0+0); LW r1,(r0+0) -> after three cycles r4=1, r0=1, r1=2 (third load reads MEM[1]).
- Continue with ADD r2=r1+r0 and SW MEM[r2+0]=r2 -> r2=3, MEM[3]=3, other MEM unchanged.
- BEQ r2,r2,offset 1 at pc 5 -> pc goes 5,7 (NOP),8. ADD at 8 -> r2=3. Then pc 9 -> 0 (wrap) -> r4 reloaded to 1.
- BNE with equal operands and BEQ with unequal operands -> pc+1. Branch target >= NUM_INSTR -> pc=0.
- Hold rst=0 across several edges mid-program -> pc=0, all registers 0, MEM contents preserved.
- Address corner cases:
  - SW to address 6 -> no MEM change.
  - LW from address 6 -> destination register = 0.
  - ADD 0xFFFFFFFF+1 -> result 0.
  - SLT -1 < 1 -> 1.
